// File: rtl/tff_bank.sv
// -----------------------------------------------------------------------------
// tff_bank
//
// Bank of WIDTH toggle flip-flops driven by asynchronous toggle requests
// (typically board buttons). Each request is synchronised into the sysclk
// domain. In level mode a high request toggles its bit on every cycle. In edge
// mode a request toggles its bit once per rising edge. A saturating counter
// accumulates the total number of individual bit toggles.
//
// Parameters:
//   WIDTH        number of toggle flip-flops (1..32)
//   SYNC_STAGES  synchroniser depth on t_in (>= 2)
//   CNT_W        width of toggle_cnt (>= 2)
//
// Ports:
//   sysclk      system clock, all state changes on its rising edge
//   reset_n     asynchronous active-low reset, clears every flop
//   t_in        toggle requests, asynchronous to sysclk, one per bit
//   mode        0 = level mode, 1 = edge mode
//   clr         synchronous clear of q, toggled and toggle_cnt (active high)
//   hold        freezes q and toggle_cnt, discards requests (active high)
//   q           flip-flop states
//   toggled     one-cycle pulse: at least one q bit changed on the last edge
//   toggle_cnt  saturating total of individual bit toggles
//   cnt_sat     high while toggle_cnt is all-ones
// -----------------------------------------------------------------------------
module tff_bank #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] t_in,
  input  logic             mode,
  input  logic             clr,
  input  logic             hold,
  output logic [WIDTH-1:0] q,
  output logic             toggled,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat
);

  localparam int PC_W = $clog2(WIDTH + 1);
  // The sum must also hold a popcount that is wider than the counter itself
  // (for example a very narrow counter on a wide bank), so take the larger.
  localparam int SUM_W = (CNT_W + 1 > PC_W + 1) ? CNT_W + 1 : PC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  t_sync;
  logic [WIDTH-1:0]                  t_prev;
  logic [WIDTH-1:0]                  tv;
  logic [PC_W-1:0]                   pop;
  logic [SUM_W-1:0]                  sum;
  logic [CNT_W-1:0]                  cnt_next;

  assign t_sync = sync_r[SYNC_STAGES-1];

  // Synchroniser chain and one-cycle delayed copy for edge detection. These
  // keep running through clr and hold, so an edge seen while holding is
  // already consumed in t_prev when hold drops.
  // NOTE: every synchroniser stage is reset as well; otherwise a stale
  // request left over from before reset could toggle q right after release.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      t_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its neighbour, which is what turns this into a shift chain.
      sync_r <= {sync_r[SYNC_STAGES-2:0], t_in};
      t_prev <= t_sync;
    end
  end

  // Toggle vector and its population count.
  // NOTE: pop gets a default before the loop, so no latch is inferred.
  always_comb begin
    tv  = mode ? (t_sync & ~t_prev) : t_sync;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PC_W'(tv[i]);
    end
  end

  // Widened sum, then clamp so the counter never wraps.
  always_comb begin
    sum      = SUM_W'(toggle_cnt) + SUM_W'(pop);
    cnt_next = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  // Flip-flop bank with priority clr > hold > normal operation.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      q          <= '0;
      toggled    <= 1'b0;
      toggle_cnt <= '0;
    end else if (clr) begin
      q          <= '0;
      toggled    <= 1'b0;
      toggle_cnt <= '0;
    end else if (hold) begin
      toggled    <= 1'b0;
    end else begin
      q          <= q ^ tv;
      toggled    <= |tv;
      toggle_cnt <= cnt_next;
    end
  end

  assign cnt_sat = (toggle_cnt == CNT_MAX);

endmodule

// File: tb/tb_tff_bank.sv
// -----------------------------------------------------------------------------
// tb_tff_bank
//
// Drives three tff_bank instances (4 bits / 2 stages / 8-bit counter,
// 1 bit / 3 stages / 4-bit counter, 32 bits / 3 stages / 8-bit counter)
// through directed scenarios and a randomized run. A behavioural model treats
// each synchroniser as "the request sampled SYNC_STAGES edges ago" and checks
// every output of every instance once per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_tff_bank;

  localparam int NI = 3;

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic [3:0]  t_in0;
  logic [0:0]  t_in1;
  logic [31:0] t_in2;
  logic        mode;
  logic        clr;
  logic        hold;

  logic [3:0]  q0;
  logic        tog0;
  logic [7:0]  cnt0;
  logic        sat0;
  logic [0:0]  q1;
  logic        tog1;
  logic [3:0]  cnt1;
  logic        sat1;
  logic [31:0] q2;
  logic        tog2;
  logic [7:0]  cnt2;
  logic        sat2;

  int checks = 0;
  int errors = 0;
  int tg_hi0 = 0;
  int tg_base;

  always #5 sysclk = ~sysclk;

  tff_bank #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(8)) u0 (
    .sysclk(sysclk), .reset_n(reset_n), .t_in(t_in0), .mode(mode), .clr(clr),
    .hold(hold), .q(q0), .toggled(tog0), .toggle_cnt(cnt0), .cnt_sat(sat0)
  );

  tff_bank #(.WIDTH(1), .SYNC_STAGES(3), .CNT_W(4)) u1 (
    .sysclk(sysclk), .reset_n(reset_n), .t_in(t_in1), .mode(mode), .clr(clr),
    .hold(hold), .q(q1), .toggled(tog1), .toggle_cnt(cnt1), .cnt_sat(sat1)
  );

  tff_bank #(.WIDTH(32), .SYNC_STAGES(3), .CNT_W(8)) u2 (
    .sysclk(sysclk), .reset_n(reset_n), .t_in(t_in2), .mode(mode), .clr(clr),
    .hold(hold), .q(q2), .toggled(tog2), .toggle_cnt(cnt2), .cnt_sat(sat2)
  );

  // ---------------------------------------------------------------------------
  // Per-instance parameters and accessors
  // ---------------------------------------------------------------------------
  function automatic int stages(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int cmax(int i);
    return (i == 1) ? 15 : 255;
  endfunction

  function automatic logic [31:0] sample(int i);
    case (i)
      0:       return 32'(t_in0);
      1:       return 32'(t_in1);
      default: return t_in2;
    endcase
  endfunction

  function automatic logic [31:0] dut_q(int i);
    case (i)
      0:       return 32'(q0);
      1:       return 32'(q1);
      default: return q2;
    endcase
  endfunction

  function automatic logic dut_tog(int i);
    case (i)
      0:       return tog0;
      1:       return tog1;
      default: return tog2;
    endcase
  endfunction

  function automatic logic [31:0] dut_cnt(int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  function automatic logic dut_sat(int i);
    case (i)
      0:       return sat0;
      1:       return sat1;
      default: return sat2;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model. past[i][k] is the request sampled k+1 edges before the
  // current edge; the synchronised request is the one sampled SYNC_STAGES
  // edges ago and its previous value the one before that.
  // ---------------------------------------------------------------------------
  logic [31:0] past [NI][5];
  logic [31:0] m_q  [NI];
  logic        m_tog[NI];
  int          m_cnt[NI];

  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NI; i++) begin
        m_q[i]   <= '0;
        m_tog[i] <= 1'b0;
        m_cnt[i] <= 0;
        for (int k = 0; k < 5; k++) past[i][k] <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        automatic logic [31:0] ts = past[i][stages(i)-1];
        automatic logic [31:0] tp = past[i][stages(i)];
        automatic logic [31:0] tv = mode ? (ts & ~tp) : ts;
        automatic int          nc = m_cnt[i] + $countones(tv);
        if (clr) begin
          m_q[i]   <= '0;
          m_tog[i] <= 1'b0;
          m_cnt[i] <= 0;
        end else if (hold) begin
          m_tog[i] <= 1'b0;
        end else begin
          m_q[i]   <= m_q[i] ^ tv;
          m_tog[i] <= (tv != 0);
          m_cnt[i] <= (nc > cmax(i)) ? cmax(i) : nc;
        end
        for (int k = 4; k > 0; k--) past[i][k] <= past[i][k-1];
        past[i][0] <= sample(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.q", i), dut_q(i), m_q[i]);
      check($sformatf("u%0d.toggled", i), 32'(dut_tog(i)), 32'(m_tog[i]));
      check($sformatf("u%0d.toggle_cnt", i), dut_cnt(i), 32'(m_cnt[i]));
      check($sformatf("u%0d.cnt_sat", i), 32'(dut_sat(i)),
            32'(m_cnt[i] == cmax(i)));
    end
    if (tog0) tg_hi0++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge sysclk);
      compare_all();
    end
  endtask

  task automatic set_t(input logic [3:0] v);
    t_in0 = v;
    t_in1 = v[0];
    t_in2 = {8{v}};
  endtask

  task automatic clear_all();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0;
    mode    = 1'b0;
    clr     = 1'b0;
    hold    = 1'b0;
    set_t(4'h0);
    #22 reset_n = 1'b1;
    step(1);

    // Reset values
    check("reset q0", 32'(q0), 32'h0);
    check("reset toggled0", 32'(tog0), 32'h0);
    check("reset cnt0", 32'(cnt0), 32'h0);
    check("reset sat0", 32'(sat0), 32'h0);
    check("reset q2", q2, 32'h0);
    step(3);

    // Level mode: request held for 5 edges, latency 2 (u0) and 3 (u1/u2)
    clear_all();
    step(2);
    tg_base = tg_hi0;
    set_t(4'h1);
    @(posedge sysclk);                       // E0 captures the request
    step(1);
    @(posedge sysclk); #1;                   // E1
    check("lat E1 q0", 32'(q0), 32'h0);
    step(1);
    @(posedge sysclk); #1;                   // E2
    check("lat E2 q0", 32'(q0), 32'h1);
    check("lat E2 q1", 32'(q1), 32'h0);
    check("lat E2 toggled0", 32'(tog0), 32'h1);
    step(1);
    @(posedge sysclk); #1;                   // E3
    check("lat E3 q0", 32'(q0), 32'h0);
    check("lat E3 q1", 32'(q1), 32'h1);
    step(1);
    @(posedge sysclk);                       // E4, last edge with request high
    step(1);
    set_t(4'h0);
    step(4);
    check("level q0", 32'(q0), 32'h1);
    check("level cnt0", 32'(cnt0), 32'd5);
    check("level toggled cycles", 32'(tg_hi0 - tg_base), 32'd5);
    check("level q1", 32'(q1), 32'h1);
    check("level cnt1", 32'(cnt1), 32'd5);
    check("level q2", q2, 32'h1111_1111);
    check("level cnt2", 32'(cnt2), 32'd40);

    // Edge mode: two presses of 0110
    clear_all();
    mode = 1'b1;
    step(1);
    tg_base = tg_hi0;
    set_t(4'h6);
    step(10);
    check("edge press1 q0", 32'(q0), 32'h6);
    check("edge press1 cnt0", 32'(cnt0), 32'd2);
    check("edge press1 q2", q2, 32'h6666_6666);
    set_t(4'h0);
    step(4);
    set_t(4'h6);
    step(10);
    set_t(4'h0);
    step(4);
    check("edge press2 q0", 32'(q0), 32'h0);
    check("edge cnt0", 32'(cnt0), 32'd4);
    check("edge cnt2", 32'(cnt2), 32'd32);
    check("edge toggled pulses", 32'(tg_hi0 - tg_base), 32'd2);

    // Priority: clr and hold with active level requests
    mode = 1'b0;
    set_t(4'hF);
    clr  = 1'b1;
    hold = 1'b1;
    step(6);
    check("prio q0", 32'(q0), 32'h0);
    check("prio cnt0", 32'(cnt0), 32'h0);
    check("prio toggled0", 32'(tog0), 32'h0);
    check("prio q2", q2, 32'h0);
    set_t(4'h0);
    step(4);
    // Hold alone, edge-mode press entirely inside the hold window
    clr  = 1'b0;
    mode = 1'b1;
    step(2);
    set_t(4'h3);
    step(3);
    set_t(4'h0);
    step(4);
    hold = 1'b0;
    tg_base = tg_hi0;
    step(5);
    check("hold q0", 32'(q0), 32'h0);
    check("hold cnt0", 32'(cnt0), 32'h0);
    check("hold q2", q2, 32'h0);
    check("hold no toggle", 32'(tg_hi0 - tg_base), 32'd0);

    // Saturation: all bits held in level mode
    clear_all();
    mode = 1'b0;
    set_t(4'hF);
    step(70);
    check("sat cnt0", 32'(cnt0), 32'd255);
    check("sat flag0", 32'(sat0), 32'h1);
    check("sat cnt1", 32'(cnt1), 32'd15);
    check("sat flag1", 32'(sat1), 32'h1);
    check("sat cnt2", 32'(cnt2), 32'd255);
    set_t(4'h0);
    step(4);

    // Asynchronous reset mid-run with q0 = 1010
    clear_all();
    mode = 1'b1;
    set_t(4'hF);
    step(4);
    set_t(4'h0);
    step(4);
    set_t(4'h5);
    step(4);
    set_t(4'h0);
    step(4);
    check("pre-reset q0", 32'(q0), 32'hA);
    check("pre-reset cnt0", 32'(cnt0), 32'd6);
    #2 reset_n = 1'b0;
    #1;
    check("async reset q0", 32'(q0), 32'h0);
    check("async reset cnt0", 32'(cnt0), 32'h0);
    check("async reset toggled0", 32'(tog0), 32'h0);
    check("async reset cnt2", 32'(cnt2), 32'h0);
    #29 reset_n = 1'b1;
    step(5);
    check("post-reset q0", 32'(q0), 32'h0);
    check("post-reset cnt0", 32'(cnt0), 32'h0);
    check("post-reset toggled0", 32'(tog0), 32'h0);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      step(1);
      if ($urandom_range(0, 3) == 0) t_in0 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) t_in1 = 1'($urandom);
      if ($urandom_range(0, 3) == 0) t_in2 = $urandom & $urandom;
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #3 reset_n = 1'b0;
        #4 reset_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
